// File: rtl/rd_ptr_ctrl_pkg.sv
// Shared defaults and helpers for the multi-stream buffer read-pointer controller.
// Holds stream/port/pointer defaults and the flat port-major matrix index helper.
package msb_pkg;

    localparam int nstrms_def    = 64;
    localparam int nports_def    = 8;
    localparam int ptr_width_def = 4;

    function automatic int sid_w(input int nstrms);
        return $clog2(nstrms);
    endfunction

    function automatic int cnt_w(input int nports);
        return $clog2(nports + 1);
    endfunction

    function automatic int occ_w(input int ptr_width);
        return ptr_width + 1;
    endfunction

    // bit position of (port p, stream s) in a port-major flat matrix
    function automatic int mtx_idx(input int p, input int s, input int nstrms);
        return p * nstrms + s;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// Request/grant, write and clear bundle between the read ports, write path
// and the read-pointer controller.
interface rd_ptr_ctrl_if
    import msb_pkg::*;
#(
    parameter int nstrms    = nstrms_def,
    parameter int nports    = nports_def,
    parameter int ptr_width = ptr_width_def
) ();

    localparam int sid_width = sid_w(nstrms);

    logic [nports*nstrms-1:0]        i_req_v;
    logic [nports*nstrms-1:0]        i_req_r;
    logic                            i_wr_v;
    logic                            i_wr_r;
    logic [sid_width-1:0]            i_wr_sid;
    logic [ptr_width-1:0]            o_wr_addr;
    logic                            i_clr_v;
    logic [sid_width-1:0]            i_clr_sid;
    logic [nstrms*ptr_width-1:0]     o_ptrs;
    logic [nstrms*(ptr_width+1)-1:0] o_occ;
    logic [nstrms-1:0]               o_empty;

    modport slave (
        input  i_req_v, i_wr_v, i_wr_sid, i_clr_v, i_clr_sid,
        output i_req_r, i_wr_r, o_wr_addr, o_ptrs, o_occ, o_empty
    );

    modport master (
        output i_req_v, i_wr_v, i_wr_sid, i_clr_v, i_clr_sid,
        input  i_req_r, i_wr_r, o_wr_addr, o_ptrs, o_occ, o_empty
    );

endinterface

// File: rtl/rd_ptr_ctrl_strm.sv
// Pointer and occupancy state of one stream, with prefix-ordered
// grants of that stream's request column.
module rd_ptr_strm
    import msb_pkg::*;
#(
    parameter int nports    = nports_def,
    parameter int ptr_width = ptr_width_def
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [nports-1:0]    req,
    input  logic                 wr,
    input  logic                 clr,
    output logic [nports-1:0]    rdy,
    output logic [ptr_width-1:0] ptr,
    output logic [ptr_width:0]   occ,
    output logic                 empty
);

    localparam int cnt_width = cnt_w(nports);
    localparam int occ_width = occ_w(ptr_width);
    localparam int aw        = max_int(cnt_width, occ_width);

    logic [cnt_width-1:0] below;
    logic [cnt_width-1:0] nrd;

    // grant port p while fewer than occ lower ports request this stream
    always_comb begin
        below = '0;
        nrd   = '0;
        rdy   = '0;
        for (int p = 0; p < nports; p++) begin
            rdy[p] = (aw'(below) < aw'(occ)) && !clr;
            nrd    = nrd + cnt_width'(req[p] && rdy[p]);
            below  = below + cnt_width'(req[p]);
        end
    end

    // advance head by the fired reads, account writes; clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            occ <= '0;
        end else if (clr) begin
            ptr <= '0;
            occ <= '0;
        end else begin
            ptr <= ptr + ptr_width'(nrd);
            occ <= occ + occ_width'(wr) - occ_width'(nrd);
        end
    end

    assign empty = (occ == '0);

    a_no_underflow : assert property (
        @(posedge clk) disable iff (!reset) aw'(nrd) <= aw'(occ));

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!reset)
        occ <= {1'b1, {ptr_width{1'b0}}});

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-pointer and occupancy controller: per-stream grant arbitration,
// write admission with L1 slot address, and single-stream flush.
module rd_ptr_ctrl
    import msb_pkg::*;
#(
    parameter int nstrms    = nstrms_def,
    parameter int nports    = nports_def,
    parameter int ptr_width = ptr_width_def
) (
    input  logic          clk,
    input  logic          reset,
    rd_ptr_ctrl_if.slave  bus
);

    localparam int sid_width = sid_w(nstrms);
    localparam int occ_width = occ_w(ptr_width);
    localparam logic [occ_width-1:0] cap = {1'b1, {ptr_width{1'b0}}};

    logic [ptr_width-1:0] ptr [nstrms];
    logic [occ_width-1:0] occ [nstrms];
    logic [nstrms-1:0]    clr_hit;
    logic [nstrms-1:0]    wr_sel;
    logic [nstrms-1:0]    wr_hit;
    logic                 wr_full;
    logic                 wr_ok;
    logic [ptr_width-1:0] wr_addr;

    // one-hot decode of the clear and write stream ids
    always_comb begin
        clr_hit = '0;
        wr_sel  = '0;
        for (int s = 0; s < nstrms; s++) begin
            clr_hit[s] = bus.i_clr_v && (bus.i_clr_sid == sid_width'(s));
            wr_sel[s]  = (bus.i_wr_sid == sid_width'(s));
        end
    end

    // admit a write only into a non-full, non-flushing stream
    always_comb begin
        wr_full = 1'b0;
        wr_addr = '0;
        for (int s = 0; s < nstrms; s++) begin
            if (wr_sel[s]) begin
                wr_full = (occ[s] == cap);
                wr_addr = ptr[s] + occ[s][ptr_width-1:0];
            end
        end
        wr_ok  = reset && !wr_full && !(|(clr_hit & wr_sel));
        wr_hit = wr_sel & {nstrms{bus.i_wr_v && wr_ok}};
    end

    assign bus.i_wr_r    = wr_ok;
    assign bus.o_wr_addr = wr_addr;

    for (genvar s = 0; s < nstrms; s++) begin : g_strm
        logic [nports-1:0] col;
        logic [nports-1:0] rdy;
        logic              empty;

        for (genvar p = 0; p < nports; p++) begin : g_col
            assign col[p] = bus.i_req_v[mtx_idx(p, s, nstrms)];
            assign bus.i_req_r[mtx_idx(p, s, nstrms)] = rdy[p];
        end

        rd_ptr_strm #(
            .nports    (nports),
            .ptr_width (ptr_width)
        ) u_strm (
            .clk   (clk),
            .reset (reset),
            .req   (col),
            .wr    (wr_hit[s]),
            .clr   (clr_hit[s]),
            .rdy   (rdy),
            .ptr   (ptr[s]),
            .occ   (occ[s]),
            .empty (empty)
        );

        assign bus.o_ptrs[s*ptr_width +: ptr_width] = ptr[s];
        assign bus.o_occ[s*occ_width +: occ_width]  = occ[s];
        assign bus.o_empty[s]                       = empty;
    end

    for (genvar p = 0; p < nports; p++) begin : g_row
        a_row_onehot : assert property (
            @(posedge clk) disable iff (!reset)
            $onehot0(bus.i_req_v[p*nstrms +: nstrms]));
    end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Scoreboard bench for rd_ptr_ctrl: randomized and directed traffic checked
// against a per-stream ptr/occ model of the grant and admission rules.
module tb_rd_ptr_ctrl;

    localparam int ns = 4;
    localparam int np = 4;
    localparam int pw = 3;
    localparam int cap = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    rd_ptr_ctrl_if #(.nstrms(ns), .nports(np), .ptr_width(pw)) bus ();

    rd_ptr_ctrl #(.nstrms(ns), .nports(np), .ptr_width(pw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] req_r;
        logic        wr_r;
        logic [2:0]  wr_addr;
        logic [11:0] ptrs;
        logic [15:0] occ;
        logic [3:0]  empty;
    } exp_t;

    exp_t sbq[$];
    int   nchk = 0;
    int   nerr = 0;
    int   mptr[ns];
    int   mocc[ns];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // stream requested by each port, -1 for none
    function automatic logic [15:0] rq(input int a, input int b,
                                       input int c, input int d);
        int sel[np];
        logic [15:0] r;
        sel = '{a, b, c, d};
        r = '0;
        for (int p = 0; p < np; p++)
            if (sel[p] >= 0) r[p*ns + sel[p]] = 1'b1;
        return r;
    endfunction

    // one cycle: drive inputs, predict the outputs, advance the model
    task automatic cyc(input logic [15:0] req, input logic wv, input int wsid,
                       input logic cv, input int csid);
        exp_t e;
        int nreq;
        int nrd[ns];
        logic hit;
        @(posedge clk);
        #1;
        bus.i_req_v   = req;
        bus.i_wr_v    = wv;
        bus.i_wr_sid  = 2'(wsid);
        bus.i_clr_v   = cv;
        bus.i_clr_sid = 2'(csid);
        e.req_r = '0;
        for (int s = 0; s < ns; s++) begin
            hit = cv && (csid == s);
            nreq = 0;
            nrd[s] = 0;
            for (int p = 0; p < np; p++) begin
                e.req_r[p*ns + s] = (nreq < mocc[s]) && !hit;
                if (req[p*ns + s]) begin
                    if (nreq < mocc[s] && !hit) nrd[s]++;
                    nreq++;
                end
            end
        end
        e.wr_r    = (mocc[wsid] < cap) && !(cv && csid == wsid);
        e.wr_addr = 3'((mptr[wsid] + mocc[wsid]) % cap);
        for (int s = 0; s < ns; s++) begin
            e.ptrs[s*pw +: pw] = 3'(mptr[s]);
            e.occ[s*4 +: 4]    = 4'(mocc[s]);
            e.empty[s]         = (mocc[s] == 0);
        end
        sbq.push_back(e);
        for (int s = 0; s < ns; s++) begin
            if (cv && csid == s) begin
                mptr[s] = 0;
                mocc[s] = 0;
            end else begin
                mptr[s] = (mptr[s] + nrd[s]) % cap;
                mocc[s] = mocc[s] - nrd[s]
                        + ((wv && e.wr_r && wsid == s) ? 1 : 0);
            end
        end
    endtask

    task automatic idle();
        cyc('0, 1'b0, 0, 1'b0, 0);
    endtask

    // monitor: compare every settled cycle with its predicted response
    always @(negedge clk) begin : mon
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("req_r", 32'(bus.i_req_r), 32'(e.req_r));
            chk("wr_r", 32'(bus.i_wr_r), 32'(e.wr_r));
            chk("wr_addr", 32'(bus.o_wr_addr), 32'(e.wr_addr));
            chk("ptrs", 32'(bus.o_ptrs), 32'(e.ptrs));
            chk("occ", 32'(bus.o_occ), 32'(e.occ));
            chk("empty", 32'(bus.o_empty), 32'(e.empty));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        int a, b, c, d;
        for (int s = 0; s < ns; s++) begin
            mptr[s] = 0;
            mocc[s] = 0;
        end
        bus.i_req_v   = rq(0, 1, 2, 3);
        bus.i_wr_v    = 1'b1;
        bus.i_wr_sid  = '0;
        bus.i_clr_v   = 1'b0;
        bus.i_clr_sid = '0;
        #2;
        chk("rst_req_r", 32'(bus.i_req_r), 0);
        chk("rst_wr_r", 32'(bus.i_wr_r), 0);
        chk("rst_ptrs", 32'(bus.o_ptrs), 0);
        chk("rst_occ", 32'(bus.o_occ), 0);
        chk("rst_empty", 32'(bus.o_empty), 32'hF);
        bus.i_req_v = '0;
        bus.i_wr_v  = 1'b0;
        #10 reset = 1'b1;

        repeat (3) cyc('0, 1'b1, 2, 1'b0, 0);
        idle();
        #1;
        chk("t1_occ2", 32'(bus.o_occ[11:8]), 3);
        chk("t1_empty", 32'(bus.o_empty), 32'b1011);

        cyc(rq(2, 2, 0, 2), 1'b0, 0, 1'b0, 0);
        #1;
        chk("t2_rdy", 32'({bus.i_req_r[14], bus.i_req_r[8],
                            bus.i_req_r[6], bus.i_req_r[2]}), 32'b1011);
        idle();
        #1;
        chk("t2_ptr2", 32'(bus.o_ptrs[8:6]), 3);
        chk("t2_occ2", 32'(bus.o_occ[11:8]), 0);

        repeat (2) cyc('0, 1'b1, 1, 1'b0, 0);
        cyc(rq(1, 1, 1, 1), 1'b0, 0, 1'b0, 0);
        #1;
        chk("t3_rdy", 32'({bus.i_req_r[13], bus.i_req_r[9],
                            bus.i_req_r[5], bus.i_req_r[1]}), 32'b0011);
        idle();
        #1;
        chk("t3_ptr1", 32'(bus.o_ptrs[5:3]), 2);
        chk("t3_occ1", 32'(bus.o_occ[7:4]), 0);

        repeat (8) cyc('0, 1'b1, 0, 1'b0, 0);
        cyc(rq(0, -1, -1, -1), 1'b1, 0, 1'b0, 0);
        #1;
        chk("t4_full_wr_r", 32'(bus.i_wr_r), 0);
        chk("t4_rd_rdy", 32'(bus.i_req_r[0]), 1);
        cyc('0, 1'b1, 0, 1'b0, 0);
        #1;
        chk("t4_wr_r", 32'(bus.i_wr_r), 1);
        chk("t4_wr_addr", 32'(bus.o_wr_addr), 0);

        repeat (6) cyc('0, 1'b1, 3, 1'b0, 0);
        cyc(rq(3, 3, 3, 3), 1'b0, 0, 1'b0, 0);
        cyc(rq(3, 3, -1, -1), 1'b0, 0, 1'b0, 0);
        repeat (4) cyc('0, 1'b1, 3, 1'b0, 0);
        cyc(rq(3, 3, 3, 3), 1'b0, 0, 1'b0, 0);
        idle();
        #1;
        chk("t5_ptr3", 32'(bus.o_ptrs[11:9]), 2);
        chk("t5_occ3", 32'(bus.o_occ[15:12]), 0);

        repeat (2) cyc('0, 1'b1, 1, 1'b0, 0);
        cyc(rq(1, -1, -1, -1), 1'b1, 1, 1'b1, 1);
        #1;
        chk("t6_clr_rdy", 32'(bus.i_req_r[1]), 0);
        chk("t6_clr_wr_r", 32'(bus.i_wr_r), 0);
        idle();
        #1;
        chk("t6_ptr1", 32'(bus.o_ptrs[5:3]), 0);
        chk("t6_occ1", 32'(bus.o_occ[7:4]), 0);

        @(posedge clk);
        #1;
        bus.i_req_v  = rq(0, 2, 3, 1);
        bus.i_wr_v   = 1'b1;
        bus.i_wr_sid = 2'd0;
        reset = 1'b0;
        #1;
        chk("mid_rst_req_r", 32'(bus.i_req_r), 0);
        chk("mid_rst_wr_r", 32'(bus.i_wr_r), 0);
        chk("mid_rst_ptrs", 32'(bus.o_ptrs), 0);
        chk("mid_rst_occ", 32'(bus.o_occ), 0);
        chk("mid_rst_empty", 32'(bus.o_empty), 32'hF);
        for (int s = 0; s < ns; s++) begin
            mptr[s] = 0;
            mocc[s] = 0;
        end
        bus.i_req_v = '0;
        bus.i_wr_v  = 1'b0;
        #2 reset = 1'b1;

        for (int i = 0; i < 600; i++) begin
            a = int'($urandom_range(0, 4)) - 1;
            b = int'($urandom_range(0, 4)) - 1;
            c = int'($urandom_range(0, 4)) - 1;
            d = int'($urandom_range(0, 4)) - 1;
            cyc(rq(a, b, c, d), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 3)));
        end
        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
